// File: rtl/i2c_xfer_seq_pkg.sv
// Shared I2C sequencer definitions: state encodings, R/W bit values and
// byte-controller command codes.
package i2c_xfer_seq_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WDOG_W = 16;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    DEV_W  = 4'd1,
    REG_A  = 4'd2,
    WR_D   = 4'd3,
    DEV_R  = 4'd4,
    RD_D   = 4'd5,
    STOP_E = 4'd6,
    GAP    = 4'd7,
    FIN    = 4'd8
  } seq_state_e;

  typedef struct packed {
    logic start;
    logic stop;
    logic read;
    logic write;
    logic tx_ack;
  } i2c_cmd_t;

  localparam i2c_cmd_t CMD_NONE     = '0;
  localparam i2c_cmd_t CMD_START_WR = '{start: 1'b1, stop: 1'b0, read: 1'b0, write: 1'b1, tx_ack: 1'b0};
  localparam i2c_cmd_t CMD_WR       = '{start: 1'b0, stop: 1'b0, read: 1'b0, write: 1'b1, tx_ack: 1'b0};
  localparam i2c_cmd_t CMD_WR_STOP  = '{start: 1'b0, stop: 1'b1, read: 1'b0, write: 1'b1, tx_ack: 1'b0};
  localparam i2c_cmd_t CMD_RD_STOP  = '{start: 1'b0, stop: 1'b1, read: 1'b1, write: 1'b0, tx_ack: 1'b1};
  localparam i2c_cmd_t CMD_STOP     = '{start: 1'b0, stop: 1'b1, read: 1'b0, write: 1'b0, tx_ack: 1'b0};

  // Command levels presented to the byte controller while in a given state
  function automatic i2c_cmd_t cmd_for_state(input seq_state_e st);
    case (st)
      DEV_W:   return CMD_START_WR;
      REG_A:   return CMD_WR;
      WR_D:    return CMD_WR_STOP;
      DEV_R:   return CMD_START_WR;
      RD_D:    return CMD_RD_STOP;
      STOP_E:  return CMD_STOP;
      default: return CMD_NONE;
    endcase
  endfunction

  function automatic logic cmd_active(input i2c_cmd_t c);
    return c.start | c.stop | c.read | c.write;
  endfunction

endpackage

// File: rtl/i2c_seq_wdog.sv
// Command watchdog: counts cycles while a byte command is pending and flags
// expiry at TO_CYCLES-1.
module i2c_seq_wdog
  import i2c_xfer_seq_pkg::*;
#(
  parameter int unsigned TO_CYCLES = 4096
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic run,
  output logic expired_c
);

  logic [WDOG_W-1:0] cnt_q;

  // Cleared whenever no command is driven, so each new command starts at 0
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else if (!run) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + WDOG_W'(1);
    end
  end

  assign expired_c = run && (cnt_q == WDOG_W'(TO_CYCLES - 1));

endmodule

// File: rtl/i2c_xfer_seq.sv
// I2C register-transaction sequencer: drives a byte controller through a
// single-register write or read, with NACK, arbitration-loss and timeout aborts.
module i2c_xfer_seq
  import i2c_xfer_seq_pkg::*;
#(
  parameter int unsigned TO_CYCLES = 4096
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req,
  input  logic              Rnw,
  input  logic [ADDR_W-1:0] Dev_addr,
  input  logic [BYTE_W-1:0] Reg_addr,
  input  logic [BYTE_W-1:0] Wdata,
  output logic              Start,
  output logic              Stop,
  output logic              Read,
  output logic              Write,
  output logic              Tx_ack,
  output logic [BYTE_W-1:0] Txd,
  input  logic              I2C_done,
  input  logic              Rx_ack,
  input  logic              I2C_al,
  input  logic [BYTE_W-1:0] Rxd,
  output logic              Busy,
  output logic              Done,
  output logic [BYTE_W-1:0] Rdata,
  output logic              Nack_err,
  output logic              Al_err,
  output logic              To_err
);

  seq_state_e        state_q, state_nxt;
  seq_state_e        ret_q, ret_nxt;
  logic              rnw_q, rnw_nxt;
  logic [ADDR_W-1:0] dev_q, dev_nxt;
  logic [BYTE_W-1:0] reg_q, reg_nxt;
  logic [BYTE_W-1:0] wdata_q, wdata_nxt;
  i2c_cmd_t          cmd_q, cmd_nxt;
  logic [BYTE_W-1:0] txd_q, txd_nxt;
  logic [BYTE_W-1:0] rdata_q, rdata_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              nack_q, nack_nxt;
  logic              al_q, al_nxt;
  logic              to_q, to_nxt;
  logic              cmd_run_c;
  logic              wdog_exp_c;

  assign cmd_run_c = cmd_active(cmd_q);

  i2c_seq_wdog #(
    .TO_CYCLES (TO_CYCLES)
  ) u_wdog (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .run       (cmd_run_c),
    .expired_c (wdog_exp_c)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      rnw_q   <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      cmd_q   <= CMD_NONE;
      txd_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      al_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ret_q   <= ret_nxt;
      rnw_q   <= rnw_nxt;
      dev_q   <= dev_nxt;
      reg_q   <= reg_nxt;
      wdata_q <= wdata_nxt;
      cmd_q   <= cmd_nxt;
      txd_q   <= txd_nxt;
      rdata_q <= rdata_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      nack_q  <= nack_nxt;
      al_q    <= al_nxt;
      to_q    <= to_nxt;
    end
  end

  // Next state plus registered outputs; outputs decode from the next state so
  // the GAP state is exactly one idle-command cycle between bytes.
  always_comb begin
    state_nxt = state_q;
    ret_nxt   = ret_q;
    rnw_nxt   = rnw_q;
    dev_nxt   = dev_q;
    reg_nxt   = reg_q;
    wdata_nxt = wdata_q;
    rdata_nxt = rdata_q;
    nack_nxt  = nack_q;
    al_nxt    = al_q;
    to_nxt    = to_q;

    if (state_q == IDLE) begin
      if (Req) begin
        state_nxt = DEV_W;
        rnw_nxt   = Rnw;
        dev_nxt   = Dev_addr;
        reg_nxt   = Reg_addr;
        wdata_nxt = Wdata;
        nack_nxt  = 1'b0;
        al_nxt    = 1'b0;
        to_nxt    = 1'b0;
      end
    end else if (I2C_al && state_q != FIN) begin
      state_nxt = FIN;
      al_nxt    = 1'b1;
    end else if (wdog_exp_c) begin
      state_nxt = FIN;
      to_nxt    = 1'b1;
    end else begin
      case (state_q)
        GAP: state_nxt = ret_q;
        FIN: state_nxt = IDLE;
        DEV_W, REG_A, DEV_R: begin
          if (I2C_done) begin
            state_nxt = GAP;
            if (Rx_ack) begin
              ret_nxt  = STOP_E;
              nack_nxt = 1'b1;
            end else if (state_q == DEV_W) begin
              ret_nxt = REG_A;
            end else if (state_q == REG_A) begin
              ret_nxt = (rnw_q == RW_READ) ? DEV_R : WR_D;
            end else begin
              ret_nxt = RD_D;
            end
          end
        end
        WR_D: begin
          if (I2C_done) begin
            state_nxt = FIN;
            if (Rx_ack) nack_nxt = 1'b1;
          end
        end
        RD_D: begin
          if (I2C_done) begin
            state_nxt = FIN;
            rdata_nxt = Rxd;
          end
        end
        STOP_E: begin
          if (I2C_done) state_nxt = FIN;
        end
        default: state_nxt = IDLE;
      endcase
    end

    cmd_nxt = cmd_for_state(state_nxt);
    case (state_nxt)
      DEV_W:   txd_nxt = {dev_nxt, RW_WRITE};
      REG_A:   txd_nxt = reg_nxt;
      WR_D:    txd_nxt = wdata_nxt;
      DEV_R:   txd_nxt = {dev_nxt, RW_READ};
      default: txd_nxt = '0;
    endcase
    busy_nxt = (state_nxt != IDLE) && (state_nxt != FIN);
    done_nxt = (state_nxt == FIN);
  end

  assign Start    = cmd_q.start;
  assign Stop     = cmd_q.stop;
  assign Read     = cmd_q.read;
  assign Write    = cmd_q.write;
  assign Tx_ack   = cmd_q.tx_ack;
  assign Txd      = txd_q;
  assign Rdata    = rdata_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Nack_err = nack_q;
  assign Al_err   = al_q;
  assign To_err   = to_q;

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed bench for i2c_xfer_seq with a hand-driven byte-controller model.
module tb_i2c_xfer_seq;

  logic       Clk;
  logic       Rst_n;
  logic       Req;
  logic       Rnw;
  logic [6:0] Dev_addr;
  logic [7:0] Reg_addr;
  logic [7:0] Wdata;
  logic       Start, Stop, Read, Write, Tx_ack;
  logic [7:0] Txd;
  logic       I2C_done;
  logic       Rx_ack;
  logic       I2C_al;
  logic [7:0] Rxd;
  logic       Busy, Done;
  logic [7:0] Rdata;
  logic       Nack_err, Al_err, To_err;

  logic [4:0] cmd;
  logic [2:0] errs;
  assign cmd  = {Start, Stop, Read, Write, Tx_ack};
  assign errs = {Nack_err, Al_err, To_err};

  int checks;
  int failures;

  i2c_xfer_seq #(.TO_CYCLES(16)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Req      (Req),
    .Rnw      (Rnw),
    .Dev_addr (Dev_addr),
    .Reg_addr (Reg_addr),
    .Wdata    (Wdata),
    .Start    (Start),
    .Stop     (Stop),
    .Read     (Read),
    .Write    (Write),
    .Tx_ack   (Tx_ack),
    .Txd      (Txd),
    .I2C_done (I2C_done),
    .Rx_ack   (Rx_ack),
    .I2C_al   (I2C_al),
    .Rxd      (Rxd),
    .Busy     (Busy),
    .Done     (Done),
    .Rdata    (Rdata),
    .Nack_err (Nack_err),
    .Al_err   (Al_err),
    .To_err   (To_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  // Issue a request; returns in the first cycle the command is expected.
  task automatic start_req(input logic rnw, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd);
    Req = 1'b1; Rnw = rnw; Dev_addr = dev; Reg_addr = ra; Wdata = wd;
    tick();
    Req = 1'b0;
    chk("req.busy", 16'(Busy), 16'h1);
  endtask

  // Check the current command, hold it, complete it and check the zero cycle after.
  task automatic serve(input string tag, input logic [4:0] exp_cmd, input logic chk_txd,
                       input logic [7:0] exp_txd, input int hold, input logic ack,
                       input logic [7:0] rxd);
    chk({tag, ".cmd"}, 16'(cmd), 16'(exp_cmd));
    if (chk_txd) chk({tag, ".txd"}, 16'(Txd), 16'(exp_txd));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold"}, 16'(cmd), 16'(exp_cmd));
    end
    I2C_done = 1'b1; Rx_ack = ack; Rxd = rxd;
    tick();
    I2C_done = 1'b0; Rx_ack = 1'b0; Rxd = 8'h00;
    chk({tag, ".gap"}, 16'(cmd), 16'h0);
  endtask

  task automatic fin(input string tag, input logic [2:0] exp_err);
    chk({tag, ".done"}, 16'(Done), 16'h1);
    chk({tag, ".busy"}, 16'(Busy), 16'h0);
    chk({tag, ".cmd0"}, 16'(cmd), 16'h0);
    chk({tag, ".err"}, 16'(errs), 16'(exp_err));
    tick();
    chk({tag, ".done_pulse"}, 16'(Done), 16'h0);
    chk({tag, ".err_hold"}, 16'(errs), 16'(exp_err));
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    Rst_n = 1'b0; Req = 1'b0; Rnw = 1'b0; Dev_addr = '0; Reg_addr = '0; Wdata = '0;
    I2C_done = 1'b0; Rx_ack = 1'b0; I2C_al = 1'b0; Rxd = '0;
    tick(); tick();
    chk("rst.cmd", 16'(cmd), 16'h0);
    chk("rst.txd", 16'(Txd), 16'h0);
    chk("rst.busy_done", 16'({Busy, Done}), 16'h0);
    chk("rst.rdata", 16'(Rdata), 16'h0);
    chk("rst.err", 16'(errs), 16'h0);
    Rst_n = 1'b1;
    tick();

    // Register write; captured inputs must not follow later input changes
    start_req(1'b0, 7'h50, 8'h10, 8'hA5);
    Wdata = 8'hFF;
    serve("w.dev", 5'b10010, 1'b1, 8'hA0, 2, 1'b0, 8'h00);
    Req = 1'b1; Dev_addr = 7'h7F;
    tick();
    Req = 1'b0;
    serve("w.reg", 5'b00010, 1'b1, 8'h10, 1, 1'b0, 8'h00);
    tick();
    serve("w.dat", 5'b01010, 1'b1, 8'hA5, 3, 1'b0, 8'h00);
    fin("w", 3'b000);
    chk("w.rdata", 16'(Rdata), 16'h0);

    // Register read
    start_req(1'b1, 7'h50, 8'h02, 8'h00);
    serve("r.dev", 5'b10010, 1'b1, 8'hA0, 1, 1'b0, 8'h00);
    tick();
    serve("r.reg", 5'b00010, 1'b1, 8'h02, 0, 1'b0, 8'h00);
    tick();
    serve("r.devr", 5'b10010, 1'b1, 8'hA1, 2, 1'b0, 8'h00);
    tick();
    serve("r.dat", 5'b01101, 1'b0, 8'h00, 4, 1'b0, 8'h3C);
    chk("r.rdata", 16'(Rdata), 16'h3C);
    fin("r", 3'b000);

    // Address NACK: stop-only command, then Nack_err
    start_req(1'b0, 7'h50, 8'h10, 8'hA5);
    serve("n.dev", 5'b10010, 1'b1, 8'hA0, 1, 1'b1, 8'h00);
    tick();
    serve("n.stop", 5'b01000, 1'b0, 8'h00, 1, 1'b0, 8'h00);
    fin("n", 3'b100);

    // Arbitration lost during the register-address byte
    start_req(1'b0, 7'h50, 8'h10, 8'hA5);
    chk("a.err_clr", 16'(errs), 16'h0);
    serve("a.dev", 5'b10010, 1'b1, 8'hA0, 0, 1'b0, 8'h00);
    tick();
    chk("a.reg", 16'(cmd), 16'b00010);
    I2C_al = 1'b1;
    tick();
    I2C_al = 1'b0;
    fin("a", 3'b010);
    chk("a.nostop", 16'(Stop), 16'h0);

    // Timeout with I2C_done withheld
    start_req(1'b0, 7'h50, 8'h10, 8'hA5);
    chk("t.cmd", 16'(cmd), 16'b10010);
    n = 0;
    while (!Done && n < 40) begin
      tick();
      n++;
    end
    chk("t.latency", 16'(n), 16'd16);
    fin("t", 3'b001);

    // Asynchronous reset in the middle of the read-data byte
    start_req(1'b1, 7'h50, 8'h02, 8'h00);
    serve("x.dev", 5'b10010, 1'b1, 8'hA0, 0, 1'b0, 8'h00);
    tick();
    serve("x.reg", 5'b00010, 1'b1, 8'h02, 0, 1'b0, 8'h00);
    tick();
    serve("x.devr", 5'b10010, 1'b1, 8'hA1, 0, 1'b0, 8'h00);
    tick();
    chk("x.rd", 16'(cmd), 16'b01101);
    #2 Rst_n = 1'b0;
    #1;
    chk("x.rst_cmd", 16'(cmd), 16'h0);
    chk("x.rst_busy", 16'({Busy, Done}), 16'h0);
    chk("x.rst_txd", 16'(Txd), 16'h0);
    chk("x.rst_rdata", 16'(Rdata), 16'h0);
    tick(); tick();
    Rst_n = 1'b1;
    tick();
    start_req(1'b0, 7'h2A, 8'h33, 8'h5A);
    serve("y.dev", 5'b10010, 1'b1, 8'h54, 0, 1'b0, 8'h00);
    tick();
    serve("y.reg", 5'b00010, 1'b1, 8'h33, 0, 1'b0, 8'h00);
    tick();
    serve("y.dat", 5'b01010, 1'b1, 8'h5A, 0, 1'b0, 8'h00);
    fin("y", 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_xfer_seq.md
I2C_XFER_SEQ -- requirements
Module: i2c_xfer_seq

Interface
REQ-001 Parameter TO_CYCLES, default 4096: cycles to wait for I2C_done before aborting a byte.
REQ-002 Clk  in  1  system clock; all state changes on the rising edge.
REQ-003 Rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Req  in  1  transaction request; sampled only in IDLE.
REQ-005 Rnw  in  1  1 = register read, 0 = register write; captured with Req.
REQ-006 Dev_addr  in  7  7-bit slave address; captured with Req.
REQ-007 Reg_addr  in  8  slave register address; captured with Req.
REQ-008 Wdata  in  8  write data; captured with Req.
REQ-009 Start, Stop, Read, Write  out  1 each  command levels to the byte controller.
REQ-010 Tx_ack  out  1  ACK bit driven by the master after a read byte (1 = NACK).
REQ-011 Txd  out  8  byte to be loaded into the byte controller shift register.
REQ-012 I2C_done  in  1  one-cycle pulse from the byte controller: command finished.
REQ-013 Rx_ack  in  1  slave ACK of the last written byte (1 = NACK); valid with I2C_done.
REQ-014 I2C_al  in  1  arbitration lost.
REQ-015 Rxd  in  8  received byte; valid with I2C_done of a read.
REQ-016 Busy, Done  out  1 each  transaction in progress; one-cycle completion pulse.
REQ-017 Rdata  out  8  read result.
REQ-018 Nack_err, Al_err, To_err  out  1 each  error flags; valid with Done.

Function
REQ-019 States: IDLE, DEV_W, REG_A, WR_D, DEV_R, RD_D, STOP_E, GAP, FIN.
REQ-020 IDLE: Req=1 captures all request inputs; Busy=1 from the next cycle; Req while Busy is ignored.
REQ-021 Write sequence: DEV_W (Start, Write, Txd={Dev_addr,0}) -> REG_A (Write, Txd=Reg_addr) -> WR_D (Write, Stop, Txd=Wdata) -> FIN.
REQ-022 Read sequence: DEV_W -> REG_A -> DEV_R (Start, Write, Txd={Dev_addr,1}) -> RD_D (Read, Stop, Tx_ack=1) -> FIN.
REQ-023 Command outputs are registered, asserted the cycle after state entry, and held stable until I2C_done is sampled high.
REQ-024 After each I2C_done, all command outputs are 0 for exactly one cycle (GAP) before the next command asserts.
REQ-025 Rx_ack=1 with I2C_done in DEV_W, REG_A or DEV_R -> STOP_E (Stop only, held until I2C_done) -> FIN with Nack_err=1.
REQ-026 Rx_ack=1 in WR_D -> FIN with Nack_err=1 (Stop already issued).
REQ-027 I2C_al=1 in any non-IDLE state -> commands drop to 0 the next cycle, FIN with Al_err=1, no Stop.
REQ-028 Watchdog: a 16-bit counter clears on each command assertion and increments while waiting; reaching TO_CYCLES-1 -> commands 0, FIN with To_err=1.
REQ-029 Priority when events coincide: I2C_al > timeout > I2C_done.
REQ-030 RD_D I2C_done loads Rxd into Rdata; Rdata is otherwise held.
REQ-031 FIN: Done=1 for one cycle, Busy=0 in the same cycle, return to IDLE; error flags hold until the next Req is accepted, then clear.

Reset
REQ-032 While Rst_n=0: state IDLE, all outputs 0, Txd=0, Rdata=0, watchdog=0, captured registers=0, regardless of the transaction in progress.

Structure
REQ-033 State encodings and the R/W bit constants go in the shared I2C defines package next to the byte-controller command codes.
REQ-034 Sub-module i2c_seq_wdog (watchdog counter) is permitted; everything else is flat.

Verification
REQ-035 Write Dev=0x50, Reg=0x10, Wdata=0xA5, all ACK -> Txd sequence 0xA0, 0x10, 0xA5; Stop with the last byte; Done with all errors 0.
REQ-036 Read Dev=0x50, Reg=0x02, slave returns 0x3C -> Txd 0xA0, 0x02, 0xA1; Read+Stop with Tx_ack=1; Rdata=0x3C at Done.
REQ-037 Write with Rx_ack=1 on the address byte -> STOP_E issues Stop, Done with Nack_err=1; REG_A never entered.
REQ-038 I2C_al pulse during REG_A -> commands 0 the next cycle, Done with Al_err=1, Stop never asserted.
REQ-039 TO_CYCLES=16, I2C_done withheld -> Done with To_err=1 sixteen cycles after the command asserts.
REQ-040 Rst_n low mid-RD_D -> all outputs 0 asynchronously; a Req after release starts cleanly from DEV_W.
